// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

   // Transmit FSM states, in frame order.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Default timing: 50 MHz system clock, 115200 baud line.
   localparam int CLK_FREQ_DEF  = 50_000_000;
   localparam int BAUD_RATE_DEF = 115_200;

   // Clock cycles per line bit (integer floor); callers keep this >= 2.
   function automatic int baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Width of a counter that runs 0..div-1.
   function automatic int baud_cnt_w(input int div);
      return $clog2(div);
   endfunction

endpackage

// File: rtl/uart_tx_buf_fifo.sv
// Synchronous FIFO: pushes are dropped when full, pops ignored when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_sys,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr_q];
   assign count   = count_q;

   // Next pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_sys or posedge rst) begin
      // NOTE: sequential state is always updated with non-blocking assignments.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array.
   always_ff @(posedge clk_sys) begin
      // NOTE: storage is deliberately not reset; reset pointers make stale entries unreachable.
      if (push_ok) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO-fed serialiser producing 8N1 frames with optional parity.
module uart_tx_buf import uart_pkg::*; #(
   parameter int Baud_Rate  = BAUD_RATE_DEF,
   parameter int Clk_Freq   = CLK_FREQ_DEF,
   parameter int DATA_LEN   = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk_sys,
   input  logic                          rst,
   input  logic [DATA_LEN-1:0]           tx_dat,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BAUD_DIV = baud_div(Clk_Freq, Baud_Rate);
   localparam int CNT_W    = baud_cnt_w(BAUD_DIV);
   localparam int BIT_W    = $clog2(DATA_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LEN - 1);

   tx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_LEN-1:0]  shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;

   logic                 fifo_pop, fifo_full, fifo_empty, push_ok, cnt_last;
   logic [DATA_LEN-1:0]  fifo_rd_data;

   sync_fifo #(
      .WIDTH (DATA_LEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys (clk_sys),
      .rst     (rst),
      .push    (tx_valid),
      .pop     (fifo_pop),
      .wr_data (tx_dat),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign push_ok  = tx_valid && !fifo_full;
   assign cnt_last = (cnt_q == CNT_LAST);
   assign tx_ready = !fifo_full;
   assign uart_tx  = tx_q;
   assign tx_busy  = busy_q;

   // Next state, baud counter, shifter, FIFO pop and registered line/busy values.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      fifo_pop = 1'b0;

      if (state_q != IDLE) cnt_d = cnt_last ? '0 : cnt_q + 1'b1;

      unique case (state_q)
         IDLE:   ;
         START:  if (cnt_last) begin
                    bit_d   = '0;
                    state_d = DATA;
                 end
         DATA:   if (cnt_last) begin
                    if (bit_q == BIT_LAST) begin
                       state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                       bit_d   = bit_q + 1'b1;
                       shift_d = shift_q >> 1;
                    end
                 end
         PARITY: if (cnt_last) state_d = STOP;
         STOP:   if (cnt_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Load the next byte from IDLE or on the last stop cycle, so frames abut.
      if (((state_q == IDLE) || ((state_q == STOP) && cnt_last)) && !fifo_empty) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_rd_data;
         par_d    = (^fifo_rd_data) ^ (PARITY_ODD != 0);
         cnt_d    = '0;
         bit_d    = '0;
         state_d  = START;
      end

      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase

      // Staying in IDLE means no pop this cycle, so the FIFO is non-empty next
      // cycle exactly when it is non-empty now or a push lands.
      busy_d = (state_d != IDLE) || !fifo_empty || push_ok;
   end

   // FSM, counter, shifter and output registers; reset forces the line high at once.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: three instances (no parity, even, odd) at BAUD_DIV=10.
module tb_uart_tx_buf;

   typedef struct {
      logic [7:0] data;
      bit         par_en;
      logic       par_bit;
      bit         contig;
   } exp_t;

   logic       clk_sys = 1'b0;
   logic       rst;
   logic [7:0] tx_dat;
   logic       tx_valid;
   int         sel;
   int         cyc = 0;

   logic       tx_valid_w [3];
   logic       tx_ready_w [3];
   logic       uart_tx_w  [3];
   logic       tx_busy_w  [3];
   logic [4:0] fifo_cnt_w [3];

   logic       line, rdy, busy;
   logic [4:0] cnt;

   exp_t       sb[$];
   int         n_chk = 0;
   int         n_err = 0;
   int         prev_end = -1;

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   assign tx_valid_w[0] = tx_valid && (sel == 0);
   assign tx_valid_w[1] = tx_valid && (sel == 1);
   assign tx_valid_w[2] = tx_valid && (sel == 2);
   assign line = uart_tx_w[sel];
   assign rdy  = tx_ready_w[sel];
   assign busy = tx_busy_w[sel];
   assign cnt  = fifo_cnt_w[sel];

   uart_tx_buf #(.Baud_Rate(100_000), .Clk_Freq(1_000_000), .DATA_LEN(8), .FIFO_DEPTH(16),
                 .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
      .clk_sys(clk_sys), .rst(rst), .tx_dat(tx_dat), .tx_valid(tx_valid_w[0]),
      .tx_ready(tx_ready_w[0]), .uart_tx(uart_tx_w[0]), .tx_busy(tx_busy_w[0]),
      .fifo_count(fifo_cnt_w[0]));

   uart_tx_buf #(.Baud_Rate(100_000), .Clk_Freq(1_000_000), .DATA_LEN(8), .FIFO_DEPTH(16),
                 .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
      .clk_sys(clk_sys), .rst(rst), .tx_dat(tx_dat), .tx_valid(tx_valid_w[1]),
      .tx_ready(tx_ready_w[1]), .uart_tx(uart_tx_w[1]), .tx_busy(tx_busy_w[1]),
      .fifo_count(fifo_cnt_w[1]));

   uart_tx_buf #(.Baud_Rate(100_000), .Clk_Freq(1_000_000), .DATA_LEN(8), .FIFO_DEPTH(16),
                 .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
      .clk_sys(clk_sys), .rst(rst), .tx_dat(tx_dat), .tx_valid(tx_valid_w[2]),
      .tx_ready(tx_ready_w[2]), .uart_tx(uart_tx_w[2]), .tx_busy(tx_busy_w[2]),
      .fifo_count(fifo_cnt_w[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input bit pe, input logic pb, input bit c);
      sb.push_back('{data: d, par_en: pe, par_bit: pb, contig: c});
   endtask

   // Present one byte for one rising edge; returns on the following negedge.
   task automatic drive(input logic [7:0] d);
      tx_dat   = d;
      tx_valid = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
      check(name, busy, 1'b0);
   endtask

   // Monitor: decode each frame on the selected line at mid-bit and score it.
   initial begin : monitor
      int         s, fl;
      bit         pen, aborted;
      logic [7:0] m_data;
      logic       m_start, m_par, m_stop;
      exp_t       e;
      forever begin
         @(negedge clk_sys);
         if (rst === 1'b0 && line === 1'b0) begin
            s       = cyc;
            pen     = (sel != 0);
            fl      = pen ? 110 : 100;
            aborted = 0;
            m_par   = 1'b0;
            repeat (5) begin @(negedge clk_sys); if (rst) aborted = 1; end
            m_start = line;
            for (int i = 0; i < 8; i++) begin
               repeat (10) begin @(negedge clk_sys); if (rst) aborted = 1; end
               m_data[i] = line;
            end
            if (pen) begin
               repeat (10) begin @(negedge clk_sys); if (rst) aborted = 1; end
               m_par = line;
            end
            repeat (10) begin @(negedge clk_sys); if (rst) aborted = 1; end
            m_stop = line;
            repeat (4) begin @(negedge clk_sys); if (rst) aborted = 1; end
            if (!aborted) begin
               check("frame_expected", (sb.size() != 0), 1'b1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("frame_start_bit", m_start, 1'b0);
                  check("frame_data", m_data, e.data);
                  check("frame_stop_bit", m_stop, 1'b1);
                  if (e.par_en) check("frame_parity", m_par, e.par_bit);
                  if (e.contig) check("frame_contiguous_start", s, prev_end);
               end
               prev_end = s + fl;
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin : stimulus
      int t0, lows, n;
      rst = 1'b1; tx_valid = 1'b0; tx_dat = '0; sel = 0;
      #1;
      check("reset_state", {line, rdy, busy, cnt}, {1'b1, 1'b1, 1'b0, 5'd0});
      repeat (3) @(negedge clk_sys);
      #2 rst = 1'b0;

      // Idle after reset release.
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         check("idle_after_reset", {line, rdy, busy, cnt}, {1'b1, 1'b1, 1'b0, 5'd0});
      end

      // Single byte A5: one-cycle latency, 10-cycle start bit, 100-cycle frame.
      expect_frame(8'hA5, 0, 1'b0, 0);
      drive(8'hA5);
      tx_valid = 1'b0;
      t0 = cyc;
      check("a5_queued", {line, busy, cnt}, {1'b1, 1'b1, 5'd1});
      @(negedge clk_sys);
      check("a5_start_latency", {line, cnt}, {1'b0, 5'd0});
      lows = 0;
      while (line == 1'b0 && lows < 50) begin
         lows++;
         @(negedge clk_sys);
      end
      check("a5_start_len", lows, 10);
      wait_idle(200, "a5_idle_timeout");
      check("a5_busy_fall", cyc - t0, 101);
      repeat (5) @(negedge clk_sys);

      // Three bytes on consecutive cycles: contiguous frames.
      expect_frame(8'h55, 0, 1'b0, 0);
      expect_frame(8'h0F, 0, 1'b0, 1);
      expect_frame(8'h80, 0, 1'b0, 1);
      drive(8'h55);
      t0 = cyc;
      drive(8'h0F);
      drive(8'h80);
      tx_valid = 1'b0;
      wait_idle(400, "burst3_idle_timeout");
      check("burst3_busy_fall", cyc - t0, 301);
      repeat (5) @(negedge clk_sys);

      // Fill to full while a frame is in flight; 17th push and push-at-pop are dropped.
      expect_frame(8'h5A, 0, 1'b0, 0);
      drive(8'h5A);
      tx_valid = 1'b0;
      @(negedge clk_sys);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) expect_frame(8'hC0 + 8'(i), 0, 1'b0, 1);
         drive(8'hC0 + 8'(i));
      end
      check("full_count", cnt, 5'd16);
      check("full_ready", rdy, 1'b0);
      tx_dat = 8'hEE;
      n = 0;
      while (cnt == 5'd16 && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      tx_valid = 1'b0;
      check("pop_frees_one", cnt, 5'd15);
      check("ready_after_pop", rdy, 1'b1);
      wait_idle(2000, "full_idle_timeout");
      repeat (5) @(negedge clk_sys);

      // Even parity on 07 -> 1, 110-cycle frame.
      sel = 1;
      @(negedge clk_sys);
      expect_frame(8'h07, 1, 1'b1, 0);
      drive(8'h07);
      tx_valid = 1'b0;
      t0 = cyc;
      wait_idle(200, "even_idle_timeout");
      check("even_busy_fall", cyc - t0, 111);
      repeat (5) @(negedge clk_sys);

      // Odd parity on 07 -> 0.
      sel = 2;
      @(negedge clk_sys);
      expect_frame(8'h07, 1, 1'b0, 0);
      drive(8'h07);
      tx_valid = 1'b0;
      t0 = cyc;
      wait_idle(200, "odd_idle_timeout");
      check("odd_busy_fall", cyc - t0, 111);
      repeat (5) @(negedge clk_sys);

      // Reset in the DATA state of the second of three queued bytes.
      sel = 0;
      @(negedge clk_sys);
      expect_frame(8'h3C, 0, 1'b0, 0);
      expect_frame(8'h00, 0, 1'b0, 1);
      expect_frame(8'hC3, 0, 1'b0, 1);
      drive(8'h3C);
      t0 = cyc;
      drive(8'h00);
      drive(8'hC3);
      tx_valid = 1'b0;
      while (cyc < t0 + 140) @(negedge clk_sys);
      check("pre_reset_mid_data", {line, busy, cnt}, {1'b0, 1'b1, 5'd1});
      #2 rst = 1'b1;
      #1;
      check("async_reset_state", {line, rdy, busy, cnt}, {1'b1, 1'b1, 1'b0, 5'd0});
      repeat (2) @(negedge clk_sys);
      #2 rst = 1'b0;
      sb.delete();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_sys);
         check("no_resume_after_reset", {line, busy, cnt}, {1'b1, 1'b0, 5'd0});
      end

      // Fresh traffic after reset still works.
      expect_frame(8'h96, 0, 1'b0, 0);
      drive(8'h96);
      tx_valid = 1'b0;
      wait_idle(200, "post_reset_idle_timeout");
      repeat (5) @(negedge clk_sys);

      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
Buffered UART transmitter that accepts bytes through a valid/ready handshake, queues them in an internal FIFO and serialises them onto uart_tx as 8N1 frames, with optional parity. It is the transmit-side counterpart to the uart_rx data_rdy path. Any producer can stream bursts into it without tracking line timing, for example the loopback top, a command responder or a debug dump engine.

Parameters:
Baud_Rate, 115200, line bit rate
Clk_Freq, 50_000_000, clk_sys frequency in Hz; BAUD_DIV = Clk_Freq/Baud_Rate (integer floor, must be >= 2; 434 at defaults)
DATA_LEN, 8, data bits per frame (5..9)
FIFO_DEPTH, 16, FIFO entries (power of two, >= 2)
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN = 0)

Ports:
clk_sys  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
tx_dat  in  DATA_LEN  byte to queue
tx_valid  in  1  tx_dat valid
tx_ready  out  1  FIFO can accept; equals !full
uart_tx  out  1  serial line, idle high
tx_busy  out  1  a frame is in progress or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Single clock domain: clk_sys. Reset is asynchronous and active-high on rst.
- Reset values: uart_tx=1, tx_busy=0, fifo_count=0, tx_ready=1, FSM=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
- Push: occurs when tx_valid && tx_ready at a rising edge. tx_ready depends only on full. When full, a push is dropped even if a pop happens in the same cycle. Data is stable in the FIFO from the cycle after the push.
- Simultaneous push and pop while not full: both take effect and fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: uart_tx=1. If the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START.
  - START: uart_tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0], LSB first. Each bit is held BAUD_DIV cycles, then shift right. After DATA_LEN bits, go to PARITY if PARITY_EN, else go to STOP.
  - PARITY: uart_tx = XOR of data bits, inverted when PARITY_ODD. Held BAUD_DIV cycles, then go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles. On the last stop cycle: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a push into an empty FIFO with the FSM in IDLE at edge N makes the pop happen at edge N+1. uart_tx is low from edge N+1.
- Frame length: BAUD_DIV*(2+DATA_LEN+PARITY_EN) cycles exactly. Back-to-back frames are contiguous.
- The baud counter runs 0..BAUD_DIV-1. The bit transition occurs on the edge where the counter equals BAUD_DIV-1.
- tx_busy = (FSM != IDLE) || !empty, registered so it matches the state.
- uart_tx is driven from a register (glitch-free).
- Reset mid-frame: the line returns high immediately (asynchronous), the FIFO contents are discarded, and no partial frame resumes after reset.
- tx_dat bits above DATA_LEN do not exist; no width extension occurs.

Decomposition:
- Package uart_pkg holds:
  - state enum/localparams: IDLE, START, DATA, PARITY, STOP
  - function baud_div(Clk_Freq, Baud_Rate)
  - localparam for the counter width ($clog2(BAUD_DIV))
- One sub-module: sync_fifo (DATA_LEN wide, FIFO_DEPTH deep, push/pop/full/empty/count, rst async active-high).
- The FSM, baud counter and shifter stay in uart_tx_buf.

Test Plan:
Sim configuration: Clk_Freq=1_000_000, Baud_Rate=100_000, so BAUD_DIV=10.
- Reset release, no traffic: uart_tx=1, tx_ready=1, tx_busy=0, fifo_count=0 for 200 cycles.
- Push 8'hA5 at edge N, PARITY_EN=0: uart_tx low from edge N+1 for 10 cycles. Data then reads 1,0,1,0,0,1,0,1 (10 cycles each), then 10 high cycles, then IDLE; the frame totals 100 cycles and tx_busy drops at its end.
- Push 8'h55, 8'h0F, 8'h80 on consecutive cycles: three contiguous 100-cycle frames with no idle gap. A line decoder recovers 55, 0F, 80 in order.
- Push 17 bytes with uart_tx stalled at frame start (FIFO_DEPTH=16): tx_ready=0 once fifo_count=16, and the 17th push is dropped. A push attempted on the same cycle as the pop when full is also dropped. Only 16 bytes go out, and the first byte's pop frees exactly one slot.
- PARITY_EN=1, PARITY_ODD=0, byte 8'h07: parity bit =1 and the frame is 110 cycles. With PARITY_ODD=1 the parity bit =0.
- Assert rst in the middle of the DATA state of the second of 3 queued bytes: uart_tx=1 the same cycle, and fifo_count=0. After release, no further transmission occurs until a new push.
